// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button filter: FSM state encoding
// and counter width sizing.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } key_state_e;

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw button; output is normalised so that
// p = 1 means pressed regardless of the button wiring.
module key_sync #(
    parameter logic RST_VAL    = 1'b1,
    parameter bit   ACTIVE_LOW = 1'b1
) (
    input  logic s_clk,
    input  logic s_rst_n,
    input  logic key_in,
    output logic p
);

    logic [1:0] sync_d;
    logic [1:0] sync_q;

    // Shift the raw input through the two metastability stages
    always_comb begin
        sync_d = {sync_q[0], key_in};
    end

    // Synchronizer flops reset to the released raw level
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign p = sync_q[1] ^ logic'(ACTIVE_LOW);

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer: emits registered press/release/long/repeat pulses
// and a stable pressed level from one raw bouncing input.
module key_filter
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int LONG_CNT     = 50_000_000,
    parameter int REPEAT_CNT   = 10_000_000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic s_clk,
    input  logic s_rst_n,
    input  logic key_in,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_rpt,
    output logic key_level
);

    localparam int DW = cnt_width(DEBOUNCE_CNT);
    localparam int HW = cnt_width(LONG_CNT);
    localparam int RW = cnt_width(REPEAT_CNT);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CNT - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CNT - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CNT - 1);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);

    logic p;

    key_state_e      state_d, state_q;
    logic [DW-1:0]   dcnt_d, dcnt_q;
    logic [HW-1:0]   hcnt_d, hcnt_q;
    logic [RW-1:0]   rcnt_d, rcnt_q;
    logic            long_done_d, long_done_q;
    logic            press_d, press_q;
    logic            release_d, release_q;
    logic            long_d, long_q;
    logic            rpt_d, rpt_q;
    logic            level_d, level_q;

    key_sync #(
        .RST_VAL    (logic'(ACTIVE_LOW)),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_sync (
        .s_clk   (s_clk),
        .s_rst_n (s_rst_n),
        .key_in  (key_in),
        .p       (p)
    );

    // Next-state, counter and event logic for the debounce/hold FSM
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        rcnt_d      = rcnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        rpt_d       = 1'b0;
        level_d     = level_q;

        case (state_q)
            IDLE: begin
                if (p) begin
                    state_d = FILT_DN;
                    dcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            FILT_DN: begin
                if (!p) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == D_LAST) begin
                    state_d     = DOWN;
                    hcnt_d      = '0;
                    rcnt_d      = '0;
                    long_done_d = 1'b0;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + D_ONE;
                end
            end
            DOWN: begin
                // hcnt saturates at the long-press point; rcnt takes over after
                if (!long_done_q) begin
                    if (hcnt_q == H_LAST) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + H_ONE;
                    end
                end else begin
                    if (rcnt_q == R_LAST) begin
                        rcnt_d = '0;
                        rpt_d  = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + R_ONE;
                    end
                end
                if (!p) begin
                    state_d = FILT_UP;
                    dcnt_d  = '0;
                end else begin
                    state_d = DOWN;
                end
            end
            FILT_UP: begin
                if (p) begin
                    state_d = DOWN;
                end else if (dcnt_q == D_LAST) begin
                    state_d     = IDLE;
                    dcnt_d      = '0;
                    hcnt_d      = '0;
                    rcnt_d      = '0;
                    long_done_d = 1'b0;
                    release_d   = 1'b1;
                    level_d     = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + D_ONE;
                end
            end
            default: begin
                state_d     = IDLE;
                dcnt_d      = '0;
                hcnt_d      = '0;
                rcnt_d      = '0;
                long_done_d = 1'b0;
                level_d     = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            rcnt_q      <= '0;
            long_done_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            rpt_q       <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            rcnt_q      <= rcnt_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            rpt_q       <= rpt_d;
            level_q     <= level_d;
        end
    end

    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_rpt     = rpt_q;
    assign key_level   = level_q;

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter: fixed vector table, directed corner
// sequences and random bursts compared against a run-length reference model.
module tb_key_filter;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic s_clk;
    logic s_rst_n;
    logic key_in;
    logic key_press, key_release, key_long, key_rpt, key_level;

    key_filter #(
        .DEBOUNCE_CNT (D),
        .LONG_CNT     (L),
        .REPEAT_CNT   (R),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .s_clk       (s_clk),
        .s_rst_n     (s_rst_n),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_rpt     (key_rpt),
        .key_level   (key_level)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit chk_model = 1'b0;

    // reference model: synchronizer delay line + run-length acceptance
    logic m_s1, m_s2, m_lvl;
    int   m_run, m_hold;
    logic e_press, e_rel, e_long, e_rpt;

    // observed event history
    int n_press = 0, n_rel = 0;
    int last_press = -1, last_long = -1;
    int rpt_e[$];

    typedef struct {
        logic key;
        logic press;
        logic rel;
        logic level;
    } vec_t;
    vec_t tbl[24];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic model_step();
        logic p;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rpt = 1'b0;
        if (!s_rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0; m_run = 0; m_hold = 0;
        end else begin
            p    = ~m_s2;
            m_s2 = m_s1;
            m_s1 = key_in;
            if (!m_lvl) begin
                m_run = p ? m_run + 1 : 0;
                if (m_run == D + 1) begin
                    m_lvl = 1'b1; m_run = 0; m_hold = 0; e_press = 1'b1;
                end
            end else begin
                // hold time advances only while no release is pending
                if (m_run == 0) begin
                    m_hold++;
                    if (m_hold == L) e_long = 1'b1;
                    else if (m_hold > L && ((m_hold - L) % R) == 0) e_rpt = 1'b1;
                end
                m_run = (!p) ? m_run + 1 : 0;
                if (m_run == D + 1) begin
                    m_lvl = 1'b0; m_run = 0; e_rel = 1'b1;
                end
            end
        end
    endtask

    task automatic tick(input logic k);
        key_in = k;
        @(posedge s_clk);
        edge_n++;
        model_step();
        #1;
        if (key_press === 1'b1) begin n_press++; last_press = edge_n; end
        if (key_release === 1'b1) n_rel++;
        if (key_long === 1'b1) last_long = edge_n;
        if (key_rpt === 1'b1) rpt_e.push_back(edge_n);
        if (chk_model) begin
            check("model_press", key_press, e_press);
            check("model_release", key_release, e_rel);
            check("model_long", key_long, e_long);
            check("model_rpt", key_rpt, e_rpt);
            check("model_level", key_level, m_lvl);
        end
    endtask

    task automatic ticks(input logic k, input int n);
        for (int i = 0; i < n; i++) tick(k);
    endtask

    initial begin
        int s, p_edge, rel0, r_edge, len;
        logic lv;

        for (int i = 0; i < 24; i++) begin
            tbl[i].key   = (i < 12) ? 1'b0 : 1'b1;
            tbl[i].press = (i + 1 == 7);
            tbl[i].rel   = (i + 1 == 19);
            tbl[i].level = (i + 1 >= 7) && (i + 1 < 19);
        end

        s_rst_n = 1'b0;
        key_in  = 1'b1;
        ticks(1'b1, 3);
        check("rst_press", key_press, 1'b0);
        check("rst_release", key_release, 1'b0);
        check("rst_long", key_long, 1'b0);
        check("rst_rpt", key_rpt, 1'b0);
        check("rst_level", key_level, 1'b0);
        s_rst_n = 1'b1;
        edge_n  = 0;

        // clean press then clean release, from the fixed table
        for (int i = 0; i < 24; i++) begin
            tick(tbl[i].key);
            check("tbl_press", key_press, tbl[i].press);
            check("tbl_release", key_release, tbl[i].rel);
            check("tbl_level", key_level, tbl[i].level);
            check("tbl_long", key_long, 1'b0);
        end
        chk_model = 1'b1;

        // bounce: short low burst rejected, press 7 edges after final fall
        rel0 = n_press;
        ticks(1'b0, 3);
        tick(1'b1);
        s = edge_n + 1;
        ticks(1'b0, 10);
        check_int("bounce_press_count", n_press - rel0, 1);
        check_int("bounce_press_edge", last_press, s + 6);
        rel0 = n_release_count();
        s = edge_n + 1;
        ticks(1'b1, 10);
        check_int("release_count", n_rel - rel0, 1);
        check_int("release_no_press", last_press < s ? 1 : 0, 1);

        // long hold with auto-repeat
        s = edge_n + 1;
        ticks(1'b0, 7);
        p_edge = s + 6;
        check_int("long_press_edge", last_press, p_edge);
        rpt_e.delete();
        ticks(1'b0, 59);
        check_int("long_edge", last_long, p_edge + 20);
        check_int("rpt_count", rpt_e.size(), 4);
        for (int i = 0; i < rpt_e.size() && i < 4; i++)
            check_int("rpt_edge", rpt_e[i], p_edge + 28 + 8 * i);
        ticks(1'b1, 10);

        // short release glitch in DOWN pauses the hold counter
        s = edge_n + 1;
        ticks(1'b0, 7);
        p_edge = s + 6;
        rel0 = n_rel;
        ticks(1'b0, 10);
        ticks(1'b1, 2);
        ticks(1'b0, 20);
        check_int("glitch_long_edge", last_long, p_edge + 22);
        check_int("glitch_no_release", n_rel - rel0, 0);
        ticks(1'b1, 10);

        // reset while held
        ticks(1'b0, 12);
        s_rst_n = 1'b0;
        #1;
        check("rst_mid_level", key_level, 1'b0);
        check("rst_mid_press", key_press, 1'b0);
        ticks(1'b0, 3);
        s_rst_n = 1'b1;
        r_edge = edge_n + 1;
        ticks(1'b0, 8);
        check_int("rst_release_press_edge", last_press, r_edge + 6);
        ticks(1'b1, 10);

        // random bursts: mostly bounces, sometimes long holds
        lv = 1'b1;
        for (int b = 0; b < 150; b++) begin
            lv  = ~lv;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                              : int'($urandom_range(1, 7));
            ticks(lv, len);
        end
        ticks(1'b1, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic int n_release_count();
        return n_rel;
    endfunction

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
Debounces one raw push-button and produces clean single-cycle event pulses plus a stable level. It sits directly upstream of vga_ctrl and drives its key_en input, which switches the display pattern. Besides the press pulse, it adds release, long-press and auto-repeat events, so hold-to-cycle modes need no changes downstream.

Parameters:
DEBOUNCE_CNT, 1_000_000, stable-input cycles required to accept an edge (20 ms at 50 MHz); must be >= 2
LONG_CNT, 50_000_000, cycles in DOWN before key_long fires (1 s); must be >= 2
REPEAT_CNT, 10_000_000, key_rpt period after key_long (200 ms); must be >= 2
ACTIVE_LOW, 1, 1: key_in = 0 means pressed; 0: key_in = 1 means pressed

Ports:
s_clk  input  1  system clock
s_rst_n  input  1  asynchronous reset, active-low
key_in  input  1  raw, asynchronous, bouncing button input
key_press  output  1  one-cycle pulse on accepted press; connects to vga_ctrl key_en
key_release  output  1  one-cycle pulse on accepted release
key_long  output  1  one-cycle pulse once per hold, LONG_CNT cycles after key_press
key_rpt  output  1  one-cycle pulse every REPEAT_CNT cycles after key_long while held
key_level  output  1  debounced level, 1 = pressed

Behaviour:
- Reset: async assert, sync release. All outputs 0, FSM in IDLE, all counters 0. Sync flops reset to the released level.
- Synchronizer: 2 flops; normalises polarity to p = 1 when pressed.
- FSM states: IDLE, FILT_DN, DOWN, FILT_UP. Single debounce counter dcnt of width clog2(DEBOUNCE_CNT).
- IDLE: if p = 1, go to FILT_DN and set dcnt = 0.
- FILT_DN:
  - if p = 0, return to IDLE (bounce rejected, no output);
  - else if dcnt == DEBOUNCE_CNT-1, go to DOWN;
  - else dcnt++.
- DOWN:
  - hold counter hcnt increments every cycle;
  - if p = 0, go to FILT_UP and set dcnt = 0.
- FILT_UP:
  - if p = 1, return to DOWN; hcnt and repeat state resume without reset;
  - else if dcnt == DEBOUNCE_CNT-1, go to IDLE;
  - else dcnt++.
- All outputs are registered.
  - key_press = 1 for exactly the cycle after the FILT_DN->DOWN transition edge.
  - key_release = 1 for exactly the cycle after FILT_UP->IDLE.
  - key_level: set with key_press, cleared with key_release; stays 1 during FILT_UP.
- Press latency: key_in held pressed from edge 1 makes key_press high after edge DEBOUNCE_CNT+3 and low after edge DEBOUNCE_CNT+4 (2 sync + 1 FSM entry + DEBOUNCE_CNT).
- Long press: hcnt = 0 on entering DOWN from FILT_DN. When hcnt reaches LONG_CNT-1, key_long pulses once and a long_done flag sets; hcnt stops incrementing after that (saturate, no wrap).
- Repeat: once long_done is set, rcnt counts 0..REPEAT_CNT-1 and wraps. key_rpt pulses at each wrap, so the first key_rpt comes REPEAT_CNT cycles after key_long.
  - Counting pauses in FILT_UP and resumes on return to DOWN.
  - hcnt, rcnt and long_done clear on entering IDLE.
- Counter widths are sized from their parameters; no counter may wrap except rcnt.
- Events are mutually exclusive by construction. key_press and key_long can never coincide because LONG_CNT >= 2.
- Reset mid-operation: if reset asserts during any state, outputs drop immediately. If the key is still held at reset release, it is treated as a fresh press, and key_press fires DEBOUNCE_CNT+3 edges after release.

Decomposition:
- Shared package key_pkg: the state enum (IDLE, FILT_DN, DOWN, FILT_UP) and a clog2-based width function for counter sizing.
- One sub-module, key_sync: 2-flop synchronizer with a reset-value parameter and polarity normalisation.

Test Plan:
Use parameters DEBOUNCE_CNT=4, LONG_CNT=20, REPEAT_CNT=8, ACTIVE_LOW=1.
1. Clean press: key_in 1->0 at edge 1, then held -> key_press high only in the cycle after edge 7; key_level=1 from then on.
2. Bounce: key_in low for 3 cycles, high for 1, then low and held -> no pulse from the first burst; key_press arrives 7 edges after the final falling edge.
3. Release: a pressed key goes 0->1 and is held -> key_release pulses once, 7 edges later; key_level=0; no spurious key_press.
4. Long hold: key held 60 cycles past key_press -> key_long pulses at 20 cycles after key_press; key_rpt pulses at +28, +36, +44, +52.
5. Release glitch in DOWN: key_in goes high for 2 cycles at hold cycle 10 -> no key_release; key_long is delayed by exactly the 2 paused cycles.
6. Reset while held: assert s_rst_n=0 in DOWN, release with key still low -> all outputs 0 during reset; key_press exactly 7 edges after reset release.
